// File: rtl/lsu_d.sv
// Data-side load/store unit: formats requests for the memory controller, holds them until ready, extends load data.
// Optional define LSU_PERF_CNT_EN adds load/store/wait-cycle performance counters.
module lsu_d #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ex_valid,
  input  logic          ex_load,
  input  logic          ex_store,
  input  logic [2:0]    ex_funct3,
  input  logic [AW-1:0] ex_addr,
  input  logic [DW-1:0] ex_wdata,
  input  logic [4:0]    ex_rd,
  output logic          stall,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_datain,
  output logic          mem_ren,
  output logic          mem_wen,
  output logic [3:0]    mem_byte_select,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_dataout,
  output logic          wb_valid,
  output logic [4:0]    wb_rd,
  output logic [DW-1:0] wb_data,
  output logic          misalign_err
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [31:0]   perf_loads,
  output logic [31:0]   perf_stores,
  output logic [31:0]   perf_wait_cycles
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  logic [1:0]  r_lane;
  logic [2:0]  r_funct3;
  logic [4:0]  r_rd;
  logic        r_load;

  logic          w_req, w_illegal, w_accept, w_done;
  logic [3:0]    w_bsel;
  logic [DW-1:0] w_wdata, w_ext;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;

  assign w_req     = ex_valid && (ex_load || ex_store);
  // funct3[1:0] encodes access size for both loads and stores once the funct3 itself is legal
  assign w_illegal = (ex_load && ex_store)
                  || (ex_load && (ex_funct3 == 3'd3 || ex_funct3 == 3'd6 || ex_funct3 == 3'd7))
                  || (ex_store && ex_funct3 > 3'd2)
                  || (ex_funct3[1:0] == 2'd1 && ex_addr[0])
                  || (ex_funct3[1:0] == 2'd2 && ex_addr[1:0] != 2'd0);
  assign w_accept  = (r_state == S_IDLE) && w_req && !w_illegal;
  assign w_done    = (r_state == S_ACCESS || r_state == S_WAIT) && mem_ready;
  assign stall     = w_accept || r_state == S_ACCESS || r_state == S_WAIT;

  always_comb begin
    w_bsel  = 4'b1111;
    w_wdata = ex_wdata;
    case (ex_funct3[1:0])
      2'd0: begin
        w_bsel  = 4'b0001 << ex_addr[1:0];
        w_wdata = {4{ex_wdata[7:0]}};
      end
      2'd1: begin
        w_bsel  = 4'b0011 << {ex_addr[1], 1'b0};
        w_wdata = {2{ex_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_byte = mem_dataout[7:0];
    case (r_lane)
      2'd1:    w_byte = mem_dataout[15:8];
      2'd2:    w_byte = mem_dataout[23:16];
      2'd3:    w_byte = mem_dataout[31:24];
      default: ;
    endcase
    w_half = r_lane[1] ? mem_dataout[31:16] : mem_dataout[15:0];
    case (r_funct3)
      3'd0:    w_ext = {{24{w_byte[7]}}, w_byte};
      3'd1:    w_ext = {{16{w_half[15]}}, w_half};
      3'd4:    w_ext = {24'd0, w_byte};
      3'd5:    w_ext = {16'd0, w_half};
      default: w_ext = mem_dataout;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state         <= S_IDLE;
      r_lane          <= '0;
      r_funct3        <= '0;
      r_rd            <= '0;
      r_load          <= 1'b0;
      mem_address     <= '0;
      mem_datain      <= '0;
      mem_ren         <= 1'b0;
      mem_wen         <= 1'b0;
      mem_byte_select <= '0;
      wb_valid        <= 1'b0;
      wb_rd           <= '0;
      wb_data         <= '0;
      misalign_err    <= 1'b0;
    end else begin
      wb_valid     <= 1'b0;
      misalign_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req && w_illegal) begin
            misalign_err <= 1'b1;
          end else if (w_accept) begin
            r_lane          <= ex_addr[1:0];
            r_funct3        <= ex_funct3;
            r_rd            <= ex_rd;
            r_load          <= ex_load;
            mem_address     <= {ex_addr[AW-1:2], 2'b00};
            mem_datain      <= w_wdata;
            mem_byte_select <= w_bsel;
            mem_ren         <= ex_load;
            mem_wen         <= ex_store;
            r_state         <= S_ACCESS;
          end
        end
        S_ACCESS, S_WAIT: begin
          if (w_done) begin
            mem_ren <= 1'b0;
            mem_wen <= 1'b0;
            if (r_load) begin
              wb_valid <= 1'b1;
              wb_rd    <= r_rd;
              wb_data  <= w_ext;
            end
            r_state <= S_RESP;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef LSU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_loads       <= '0;
      perf_stores      <= '0;
      perf_wait_cycles <= '0;
    end else begin
      if (w_done && r_load)  perf_loads  <= perf_loads + 32'd1;
      if (w_done && !r_load) perf_stores <= perf_stores + 32'd1;
      if (r_state == S_WAIT) perf_wait_cycles <= perf_wait_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lsu_d.sv
// Bench for lsu_d: vector table of legal accesses with a response scoreboard, plus illegal, back-to-back and reset sequences.
module tb_lsu_d;
  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_load, ex_store;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_wdata;
  logic [4:0]  ex_rd;
  logic        stall;
  logic [31:0] mem_address, mem_datain;
  logic        mem_ren, mem_wen;
  logic [3:0]  mem_byte_select;
  logic        mem_ready;
  logic [31:0] mem_dataout;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign_err;
`ifdef LSU_PERF_CNT_EN
  logic [31:0] perf_loads, perf_stores, perf_wait_cycles;
`endif

  lsu_d #(.AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .stall(stall), .mem_address(mem_address), .mem_datain(mem_datain), .mem_ren(mem_ren),
    .mem_wen(mem_wen), .mem_byte_select(mem_byte_select), .mem_ready(mem_ready),
    .mem_dataout(mem_dataout), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .misalign_err(misalign_err)
`ifdef LSU_PERF_CNT_EN
    , .perf_loads(perf_loads), .perf_stores(perf_stores), .perf_wait_cycles(perf_wait_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld, st;
    logic [2:0]  f3;
    logic [31:0] addr, wdata;
    logic [4:0]  rd;
    logic [31:0] dout;
    int          nwait;
    logic [3:0]  e_bsel;
    logic [31:0] e_addr, e_din, e_wb;
  } vec_t;

  typedef struct {
    logic        ld;
    logic [4:0]  rd;
    logic [31:0] wb;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
    ex_valid = 1'b1; ex_load = ld; ex_store = st; ex_funct3 = f3;
    ex_addr = a; ex_wdata = wd; ex_rd = rd;
  endtask

  task automatic run_req(input vec_t v);
    int   w;
    exp_t e;
    @(negedge clk);
    drive(v.ld, v.st, v.f3, v.addr, v.wdata, v.rd);
    mem_dataout = v.dout;
    mem_ready   = 1'b0;
    #1 chk("stall_accept", stall, 1);
    e.ld = v.ld; e.rd = v.rd; e.wb = v.e_wb;
    sb.push_back(e);
    @(negedge clk);
    ex_valid = 1'b0;
    chk("acc_ren", mem_ren, v.ld);
    chk("acc_wen", mem_wen, v.st);
    chk("acc_addr", mem_address, v.e_addr);
    chk("acc_bsel", mem_byte_select, v.e_bsel);
    chk("acc_din", mem_datain, v.e_din);
    chk("acc_stall", stall, 1);
    chk("acc_wbv", wb_valid, 0);
    mem_ready = (v.nwait == 0);
    w = 0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (!stall) break;
      w++;
      chk("wait_ren", mem_ren, v.ld);
      mem_ready = (w >= v.nwait);
    end
    chk("wait_cycles", w, v.nwait);
    if (sb.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      chk("resp_wbv", wb_valid, e.ld);
      if (e.ld) begin
        chk("resp_rd", wb_rd, e.rd);
        chk("resp_data", wb_data, e.wb);
      end
    end
    chk("resp_ren", mem_ren, 0);
    chk("resp_wen", mem_wen, 0);
    mem_ready = 1'b0;
    @(negedge clk);
    chk("idle_wbv", wb_valid, 0);
    chk("idle_stall", stall, 0);
  endtask

  task automatic run_bad(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic exp_err);
    @(negedge clk);
    drive(ld, st, f3, a, 32'h0, 5'd1);
    #1 chk("bad_stall", stall, 0);
    @(negedge clk);
    ex_valid = 1'b0;
    chk("bad_err", misalign_err, exp_err);
    chk("bad_ren", mem_ren, 0);
    chk("bad_wen", mem_wen, 0);
    @(negedge clk);
    chk("bad_err_pulse", misalign_err, 0);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{1'b0, 1'b1, 3'd2, 32'h104, 32'hDEADBEEF, 5'd0, 32'h0, 0, 4'b1111, 32'h104, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0, 1'b1, 3'd0, 32'h203, 32'h000000A5, 5'd0, 32'h0, 0, 4'b1000, 32'h200, 32'hA5A5A5A5, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 3'd0, 32'h102, 32'h0, 5'd7, 32'h12F45678, 3, 4'b0100, 32'h100, 32'h0, 32'hFFFFFFF4};
    vecs[3] = '{1'b1, 1'b0, 3'd4, 32'h102, 32'h0, 5'd7, 32'h12F45678, 0, 4'b0100, 32'h100, 32'h0, 32'h000000F4};
    vecs[4] = '{1'b1, 1'b0, 3'd1, 32'h102, 32'h0, 5'd12, 32'h80011234, 0, 4'b1100, 32'h100, 32'h0, 32'hFFFF8001};
    vecs[5] = '{1'b1, 1'b0, 3'd5, 32'h100, 32'h0, 5'd13, 32'h80019234, 2, 4'b0011, 32'h100, 32'h0, 32'h00009234};
    vecs[6] = '{1'b1, 1'b0, 3'd2, 32'h108, 32'h0, 5'd31, 32'hCAFEF00D, 1, 4'b1111, 32'h108, 32'h0, 32'hCAFEF00D};
    vecs[7] = '{1'b0, 1'b1, 3'd1, 32'h106, 32'h1234ABCD, 5'd0, 32'h0, 0, 4'b1100, 32'h104, 32'hABCDABCD, 32'h0};
    vecs[8] = '{1'b1, 1'b0, 3'd0, 32'h101, 32'h0, 5'd2, 32'h00007F00, 0, 4'b0010, 32'h100, 32'h0, 32'h0000007F};

    reset = 1'b0; ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_funct3 = '0;
    ex_addr = '0; ex_wdata = '0; ex_rd = '0; mem_ready = 1'b0; mem_dataout = '0;
    repeat (3) @(negedge clk);
    chk("rst_stall", stall, 0);
    chk("rst_ren", mem_ren, 0);
    chk("rst_wen", mem_wen, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_wbv", wb_valid, 0);
    chk("rst_err", misalign_err, 0);
    reset = 1'b1;

    foreach (vecs[i]) run_req(vecs[i]);

    run_bad(1'b1, 1'b0, 3'd1, 32'h101, 1'b1);  // LH odd
    run_bad(1'b1, 1'b0, 3'd2, 32'h102, 1'b1);  // LW half-aligned
    run_bad(1'b1, 1'b0, 3'd3, 32'h100, 1'b1);  // load funct3=3
    run_bad(1'b1, 1'b0, 3'd6, 32'h100, 1'b1);
    run_bad(1'b0, 1'b1, 3'd4, 32'h100, 1'b1);  // store funct3>2
    run_bad(1'b1, 1'b1, 3'd2, 32'h100, 1'b1);  // load and store
    run_bad(1'b0, 1'b1, 3'd1, 32'h103, 1'b1);  // SH odd
    run_bad(1'b0, 1'b0, 3'd2, 32'h100, 1'b0);  // neither: ignored

    // request held through RESP is only accepted in the following IDLE cycle
    @(negedge clk);
    drive(1'b0, 1'b1, 3'd2, 32'h10C, 32'h11223344, 5'd0);
    mem_ready = 1'b1;
    #1 chk("b2b_stall0", stall, 1);
    @(negedge clk);
    chk("b2b_wen", mem_wen, 1);
    chk("b2b_din", mem_datain, 32'h11223344);
    drive(1'b1, 1'b0, 3'd2, 32'h110, 32'h0, 5'd3);
    mem_dataout = 32'hA5A50F0F;
    @(negedge clk);
    chk("b2b_resp_stall", stall, 0);
    chk("b2b_resp_wbv", wb_valid, 0);
    chk("b2b_resp_wen", mem_wen, 0);
    @(negedge clk);
    chk("b2b_idle_stall", stall, 1);
    @(negedge clk);
    ex_valid = 1'b0;
    chk("b2b_ren", mem_ren, 1);
    chk("b2b_addr", mem_address, 32'h110);
    @(negedge clk);
    chk("b2b_wbv", wb_valid, 1);
    chk("b2b_rd", wb_rd, 3);
    chk("b2b_data", wb_data, 32'hA5A50F0F);
    mem_ready = 1'b0;
    @(negedge clk);

    // reset during WAIT abandons the load
    drive(1'b1, 1'b0, 3'd2, 32'h200, 32'h0, 5'd9);
    mem_dataout = 32'h55555555;
    @(negedge clk);
    ex_valid = 1'b0;
    @(negedge clk);
    chk("wr_stall", stall, 1);
    reset = 1'b0;
    @(negedge clk);
    chk("wr_ren", mem_ren, 0);
    chk("wr_stall_rst", stall, 0);
    chk("wr_addr", mem_address, 0);
    chk("wr_bsel", mem_byte_select, 0);
    chk("wr_wbdata", wb_data, 0);
    chk("wr_wbrd", wb_rd, 0);
    chk("wr_wbv", wb_valid, 0);
    reset = 1'b1;
    mem_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("wr_post_wbv", wb_valid, 0);
      chk("wr_post_ren", mem_ren, 0);
    end
    mem_ready = 1'b0;

`ifdef LSU_PERF_CNT_EN
    chk("perf_rst_loads", perf_loads, 0);
    run_req('{1'b1, 1'b0, 3'd2, 32'h300, 32'h0, 5'd4, 32'h01020304, 4, 4'b1111, 32'h300, 32'h0, 32'h01020304});
    run_req('{1'b1, 1'b0, 3'd0, 32'h301, 32'h0, 5'd5, 32'h00008000, 0, 4'b0010, 32'h300, 32'h0, 32'hFFFFFF80});
    run_req('{1'b0, 1'b1, 3'd2, 32'h304, 32'h5, 5'd0, 32'h0, 0, 4'b1111, 32'h304, 32'h5, 32'h0});
    chk("perf_loads", perf_loads, 2);
    chk("perf_stores", perf_stores, 1);
    chk("perf_wait", perf_wait_cycles, 4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/lsu_d.md
Name: lsu_d

Overview:
- Data-side load/store unit in the MEM stage, directly upstream of the data memory controller (cache + backing memory).
- Takes one load/store request per instruction from the pipeline and generates the word address, byte-select vector, replicated store data and ren/wen for the controller.
- Holds the request stable until the controller reports mem_ready, then extracts and sign/zero-extends load data for writeback.
- Drives the pipeline stall while an access is outstanding and flags misaligned or illegal accesses without touching memory.

Parameters:
- AW, 32, address width (ex_addr, mem_address)
- DW, 32, data width (fixed to 32; other values unsupported)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on rising edge of clk)
- ex_valid  in  1  request present this cycle
- ex_load  in  1  request is a load
- ex_store  in  1  request is a store
- ex_funct3  in  3  RV32 funct3 (LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2)
- ex_addr  in  AW  byte address
- ex_wdata  in  DW  store data (rs2)
- ex_rd  in  5  destination register for loads
- stall  out  1  freeze upstream pipeline
- mem_address  out  AW  {addr[31:2],2'b00}
- mem_datain  out  DW  replicated store data
- mem_ren  out  1  read enable to controller
- mem_wen  out  1  write enable to controller
- mem_byte_select  out  4  byte lanes
- mem_ready  in  1  controller access complete / not stalling
- mem_dataout  in  DW  read word from controller
- wb_valid  out  1  one-cycle pulse, load result valid
- wb_rd  out  5  load destination
- wb_data  out  DW  extended load result
- misalign_err  out  1  one-cycle pulse on misaligned/illegal request

Behaviour:
- Reset (reset==0 at edge): state=IDLE; every output 0, including mem_address, mem_datain, wb_data and wb_rd. Reset mid-access abandons the access: mem_ren/mem_wen are 0 from the next cycle, and no wb_valid is produced.
- Request accept: in IDLE with ex_valid && (ex_load ^ ex_store).
  - Legal request: latch addr, wdata, funct3, rd, type; go to ACCESS.
  - Illegal request: pulse misalign_err for one cycle; stay IDLE; no mem_ren/mem_wen.
- Illegal conditions:
  - ex_load && ex_store both high.
  - Load funct3 in {3,6,7}; store funct3 > 2.
  - Halfword with addr[0]=1.
  - Word with addr[1:0]!=0.
- ex_valid with neither ex_load nor ex_store: ignored.
- Byte select, all from latched values:
  - Byte: 4'b0001<<addr[1:0].
  - Half: 4'b0011<<{addr[1],1'b0}.
  - Word: 4'b1111.
  - The same byte select is used for loads.
- Store data: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
- ACCESS and WAIT:
  - mem_ren=load, mem_wen=store; address, byte select and data held constant.
  - Completion = mem_ready==1 sampled at a rising edge while in ACCESS or WAIT.
  - ACCESS: completion -> RESP; otherwise -> WAIT.
  - WAIT: stay until completion, then -> RESP.
  - On completion of a load, capture the extracted mem_dataout into wb_data.
- Load extraction: lane = addr[1:0] (byte) or addr[1] (half).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- RESP: one cycle.
  - wb_valid=1 for loads only; stores produce no wb_valid.
  - mem_ren/mem_wen=0; always returns to IDLE.
  - A new request is not accepted in RESP; it is accepted in the following IDLE cycle.
- stall (combinational): (IDLE && legal accept) || ACCESS || WAIT. Low in RESP and on illegal requests.
- Minimum latency: accept at edge N, ACCESS during N+1, mem_ready=1 at edge N+2 -> RESP (wb_valid) during N+2; stall high for 2 cycles.
- wb_data and wb_rd hold their last values outside RESP; wb_valid is 0 outside RESP.

Optional Feature:
- LSU_PERF_CNT_EN defined:
  - Adds outputs perf_loads[31:0], perf_stores[31:0] and perf_wait_cycles[31:0], all cleared by reset.
  - perf_loads / perf_stores increment on each completed load / store.
  - perf_wait_cycles increments on every cycle spent in WAIT.
  - All three wrap modulo 2^32.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- SW addr=0x104, wdata=0xDEADBEEF, mem_ready=1 -> mem_wen=1 during ACCESS, byte_select=1111, mem_address=0x104, stall high 2 cycles, no wb_valid.
- SB addr=0x203, wdata=0x000000A5 -> byte_select=1000, mem_datain=0xA5A5A5A5, mem_address=0x200.
- LB addr=0x102, rd=7, mem_dataout=0x12F45678, mem_ready low 3 cycles after ACCESS -> 3 WAIT cycles, then wb_valid with wb_rd=7, wb_data=0xFFFFFFF4. LBU on the same access -> 0x000000F4.
- LH addr=0x101 -> misalign_err pulse, stall=0, mem_ren=0. LW addr=0x102 -> same. Load funct3=3 -> same.
- Reset driven 0 during WAIT of LW -> next cycle state IDLE, mem_ren=0, all outputs 0, no wb_valid after release.
- With LSU_PERF_CNT_EN: 2 loads (one with 4 WAIT cycles) + 1 store -> perf_loads=2, perf_stores=1, perf_wait_cycles=4.
